stat_counter_bank: RTL and testbench
====================================

// Module: stat_counter_bank
// PURPOSE
//  Parametrised bank of CHANNELS event counters for CPU performance statistics (cycles,
//  correct/mis-predictions, load-use stalls, branch stalls, flushes). Replaces per-event
//  hand-coded counters in the mips top. Adds snapshot registers, optional auto-windowing
//  (rate sampling), wrap/saturate mode and sticky overflow flags, with one muxed,
//  registered read port feeding the 7-segment display path.
// PARAMETERS
//  CHANNELS   8   number of independent event counters (1..32)
//  WIDTH      32  counter / snapshot width in bits (>=2)
//  SATURATE   0   0: counter wraps to 0 after all-ones; 1: counter holds at all-ones
//  WINDOW     0   0: windowing off; N>0: auto snapshot+clear every N enabled cycles
//  SEL_WIDTH  5   width of sel; must satisfy 2**SEL_WIDTH >= CHANNELS
// PORTS
//  clk        in   1          system clock; all state updates on rising edge
//  rst_n      in   1          asynchronous reset, active-low
//  en         in   1          global count enable (low = freeze counting, e.g. CPU halted)
//  clear      in   1          synchronous clear of all counters and overflow flags
//  snap       in   1          capture every live counter into its snapshot register
//  inc        in   CHANNELS   per-channel event strobe; +1 per cycle while high and en=1
//  sel        in   SEL_WIDTH  channel select for rd_data
//  rd_snap    in   1          0: read live counter; 1: read snapshot register
//  rd_data    out  WIDTH      selected value, registered
//  overflow   out  CHANNELS   sticky per-channel overflow (wrap or saturate event)
//  snap_valid out  1          high once any snapshot (manual or window) has been taken
//  win_tick   out  1          one-cycle pulse when a window boundary fires
// BEHAVIOUR
//  Reset (rst_n=0, async): all counters, snapshots, overflow, rd_data, window count = 0;
//   snap_valid=0, win_tick=0. Deasserting rst_n mid-run discards all statistics.
//  Counting: cnt[i] <= cnt[i]+1 iff en && inc[i] && !clear. If en=0, inc is ignored.
//  Full-scale: when cnt[i] is all-ones and an increment occurs:
//   SATURATE=0 -> cnt[i] becomes 0; SATURATE=1 -> cnt[i] stays all-ones.
//   In both modes overflow[i] <= 1 and stays 1 until clear or reset (snap does not clear it).
//  Priority, same cycle: clear beats inc (counter -> 0, overflow -> 0).
//   snap with inc: snapshot holds the pre-edge value; counter still increments.
//   snap with clear: snapshot holds the pre-clear values; counters -> 0.
//  snap_valid <= 1 on the first snap or window tick; cleared only by reset.
//  Windowing (WINDOW>0): a window counter (clog2(WINDOW+1) bits) counts cycles with en=1.
//   When it reaches WINDOW-1 with en=1, the next edge performs an implicit snap+clear on all
//   channels (same semantics as above). The window counter returns to 0 and win_tick=1 for
//   that single cycle. External clear also resets the window counter to 0.
//   External snap does not disturb the window counter. en=0 freezes it.
//   WINDOW=0: window logic is absent; win_tick is constant 0.
//  Read port: rd_data <= rd_snap ? snapshot[sel] : cnt[sel]. Latency is 1 cycle from
//   sel/rd_snap; value is the pre-edge register contents. sel>=CHANNELS returns 0.
//  Arithmetic: unsigned, WIDTH bits, no carry-out port (overflow flag only).
// TESTING
//  1 Reset: pulse rst_n low mid-run with counters nonzero -> rd_data, overflow, snap_valid
//    all 0 immediately (async), before any clk edge.
//  2 Counting/enable: CHANNELS=8, inc=8'h05 for 10 cycles with en=1, then 5 cycles with en=0
//    -> ch0=ch2=10, other channels 0; sel=2 reads 10 one cycle later.
//  3 Overflow: WIDTH=4, drive inc[1] for 17 cycles -> SATURATE=0: cnt=1, overflow[1]=1;
//    SATURATE=1: cnt=15, overflow[1]=1; then clear -> cnt=0, overflow=0.
//  4 Priority: ch0 at 7, assert snap+clear+inc[0] together -> snapshot[0]=7, cnt[0]=0,
//    snap_valid=1.
//  5 Windowing: WINDOW=4, inc[0] held, en=1 -> win_tick pulses every 4th cycle;
//    snapshot[0]=4 after each tick, live cnt restarts at 0; en low 2 cycles stretches period
//    to 6.
//  6 Read mux: sel=9 with CHANNELS=8 -> rd_data=0; toggle rd_snap -> live/snapshot swap
//    after exactly 1 cycle.

Source files
------------

// File: rtl/stat_counter_bank.sv
// Bank of event counters with snapshot registers, optional auto-windowing,
// wrap/saturate full-scale handling, sticky overflow flags and a registered read port.
module stat_counter_bank #(
    parameter int CHANNELS  = 8,
    parameter int WIDTH     = 32,
    parameter int SATURATE  = 0,
    parameter int WINDOW    = 0,
    parameter int SEL_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clear,
    input  logic                 snap,
    input  logic [CHANNELS-1:0]  inc,
    input  logic [SEL_WIDTH-1:0] sel,
    input  logic                 rd_snap,
    output logic [WIDTH-1:0]     rd_data,
    output logic [CHANNELS-1:0]  overflow,
    output logic                 snap_valid,
    output logic                 win_tick
);

    logic [WIDTH-1:0]    cnt_reg  [CHANNELS];
    logic [WIDTH-1:0]    snap_reg [CHANNELS];
    logic [WIDTH-1:0]    cnt_next [CHANNELS];
    logic [CHANNELS-1:0] bump;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] overflow_reg;
    logic                snap_valid_reg;
    logic [WIDTH-1:0]    rd_data_reg;
    logic [WIDTH-1:0]    rd_mux;
    logic                win_fire;

    assign bump = inc & {CHANNELS{en}};

    // cnt_next is the value the counter would take ignoring clear/window restart
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign full[gi]     = &cnt_reg[gi];
            assign cnt_next[gi] = !bump[gi] ? cnt_reg[gi] :
                                  !full[gi] ? cnt_reg[gi] + WIDTH'(1) :
                                  (SATURATE != 0) ? cnt_reg[gi] : '0;
        end
    endgenerate

    generate
        if (WINDOW > 0) begin : g_win
            localparam int WC_W = $clog2(WINDOW + 1);
            localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW - 1);

            logic [WC_W-1:0] win_cnt_reg;
            logic            win_tick_reg;

            // An external clear in the boundary cycle wins and restarts the window
            assign win_fire = en && !clear && (win_cnt_reg == WC_LAST);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    win_cnt_reg  <= '0;
                    win_tick_reg <= 1'b0;
                end else begin
                    win_tick_reg <= win_fire;
                    if (clear || win_fire)
                        win_cnt_reg <= '0;
                    else if (en)
                        win_cnt_reg <= win_cnt_reg + WC_W'(1);
                end
            end

            assign win_tick = win_tick_reg;
        end else begin : g_nowin
            assign win_fire = 1'b0;
            assign win_tick = 1'b0;
        end
    endgenerate

    // A window snapshot takes the count including the boundary cycle's event,
    // so a window of N enabled cycles reports every event inside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_reg[i]  <= '0;
                snap_reg[i] <= '0;
            end
            overflow_reg   <= '0;
            snap_valid_reg <= 1'b0;
            rd_data_reg    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (win_fire)
                    snap_reg[i] <= cnt_next[i];
                else if (snap)
                    snap_reg[i] <= cnt_reg[i];

                if (clear || win_fire) begin
                    cnt_reg[i]      <= '0;
                    overflow_reg[i] <= 1'b0;
                end else begin
                    cnt_reg[i] <= cnt_next[i];
                    if (bump[i] && full[i])
                        overflow_reg[i] <= 1'b1;
                end
            end
            if (snap || win_fire)
                snap_valid_reg <= 1'b1;
            rd_data_reg <= rd_mux;
        end
    end

    // Out-of-range selects fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_WIDTH'(i))
                rd_mux = rd_snap ? snap_reg[i] : cnt_reg[i];
        end
    end

    assign rd_data    = rd_data_reg;
    assign overflow   = overflow_reg;
    assign snap_valid = snap_valid_reg;

endmodule

// File: tb/tb_stat_counter_bank.sv
// Three configurations (wrap, saturate, windowed) share one stimulus stream and are
// compared against an arithmetic reference model after every clock edge.
module tb_stat_counter_bank;

    localparam int CH = 8;

    logic       clk = 1'b0;
    logic       rst_n, en, clear, snap, rd_snap;
    logic [7:0] inc;
    logic [4:0] sel;

    logic [3:0] rd0, rd1;
    logic [5:0] rd2;
    logic [7:0] ov0, ov1, ov2;
    logic       sv0, sv1, sv2, wt0, wt1, wt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stat_counter_bank #(.CHANNELS(8), .WIDTH(4), .SATURATE(0), .WINDOW(0), .SEL_WIDTH(5)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .snap(snap), .inc(inc),
        .sel(sel), .rd_snap(rd_snap), .rd_data(rd0), .overflow(ov0),
        .snap_valid(sv0), .win_tick(wt0));

    stat_counter_bank #(.CHANNELS(8), .WIDTH(4), .SATURATE(1), .WINDOW(0), .SEL_WIDTH(5)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .snap(snap), .inc(inc),
        .sel(sel), .rd_snap(rd_snap), .rd_data(rd1), .overflow(ov1),
        .snap_valid(sv1), .win_tick(wt1));

    stat_counter_bank #(.CHANNELS(8), .WIDTH(6), .SATURATE(0), .WINDOW(4), .SEL_WIDTH(5)) dut_win (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .snap(snap), .inc(inc),
        .sel(sel), .rd_snap(rd_snap), .rd_data(rd2), .overflow(ov2),
        .snap_valid(sv2), .win_tick(wt2));

    // Reference model state, one row per instance
    longint m_cnt  [3][CH];
    longint m_snap [3][CH];
    longint m_rd   [3];
    bit [7:0] m_ov [3];
    bit     m_sv   [3];
    bit     m_wt   [3];
    int     m_wc   [3];

    function automatic int p_width(int k);  return (k == 2) ? 6 : 4; endfunction
    function automatic bit p_sat(int k);    return (k == 1);         endfunction
    function automatic int p_window(int k); return (k == 2) ? 4 : 0; endfunction

    function automatic logic [31:0] rd_obs(int k);
        case (k)
            0:       return {28'd0, rd0};
            1:       return {28'd0, rd1};
            default: return {26'd0, rd2};
        endcase
    endfunction

    function automatic logic [31:0] ov_obs(int k);
        case (k)
            0:       return {24'd0, ov0};
            1:       return {24'd0, ov1};
            default: return {24'd0, ov2};
        endcase
    endfunction

    function automatic logic [31:0] sv_obs(int k);
        case (k)
            0:       return {31'd0, sv0};
            1:       return {31'd0, sv1};
            default: return {31'd0, sv2};
        endcase
    endfunction

    function automatic logic [31:0] wt_obs(int k);
        case (k)
            0:       return {31'd0, wt0};
            1:       return {31'd0, wt1};
            default: return {31'd0, wt2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < CH; i++) begin
                m_cnt[k][i]  = 0;
                m_snap[k][i] = 0;
            end
            m_rd[k] = 0; m_ov[k] = '0; m_sv[k] = 0; m_wt[k] = 0; m_wc[k] = 0;
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            longint top = (longint'(1) << p_width(k)) - 1;
            bit     bnd = (p_window(k) > 0) && en && !clear && (m_wc[k] == p_window(k) - 1);
            m_rd[k] = (sel < CH) ? (rd_snap ? m_snap[k][sel] : m_cnt[k][sel]) : 0;
            for (int i = 0; i < CH; i++) begin
                bit     ev  = en && inc[i];
                bit     ovf = ev && (m_cnt[k][i] == top);
                longint nx  = m_cnt[k][i];
                if (ev) nx = (m_cnt[k][i] == top) ? (p_sat(k) ? top : 0) : m_cnt[k][i] + 1;
                if (bnd)       m_snap[k][i] = nx;
                else if (snap) m_snap[k][i] = m_cnt[k][i];
                m_ov[k][i]  = (clear || bnd) ? 1'b0 : (m_ov[k][i] | ovf);
                m_cnt[k][i] = (clear || bnd) ? 0 : nx;
            end
            m_sv[k] = m_sv[k] | snap | bnd;
            m_wt[k] = bnd;
            if (p_window(k) == 0 || clear || bnd) m_wc[k] = 0;
            else if (en)                          m_wc[k] = m_wc[k] + 1;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rd_data[%0d]", k),    rd_obs(k), m_rd[k][31:0]);
            chk($sformatf("overflow[%0d]", k),   ov_obs(k), {24'd0, m_ov[k]});
            chk($sformatf("snap_valid[%0d]", k), sv_obs(k), {31'd0, m_sv[k]});
            chk($sformatf("win_tick[%0d]", k),   wt_obs(k), {31'd0, m_wt[k]});
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clear = 1'b0; snap = 1'b0;
        inc = '0; sel = '0; rd_snap = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Counting and enable gating
        clear = 1'b1; step(); clear = 1'b0;
        inc = 8'h05; en = 1'b1; sel = 5'd2;
        repeat (10) step();
        en = 1'b0;
        repeat (5) step();
        inc = '0; step();
        chk("en_ch2_wrap", rd_obs(0), 32'd10);
        chk("en_ch2_sat",  rd_obs(1), 32'd10);
        sel = 5'd1; step();
        chk("en_ch1_idle", rd_obs(0), 32'd0);

        // Full-scale: 17 increments of a 4-bit counter
        en = 1'b1; clear = 1'b1; step(); clear = 1'b0;
        inc = 8'h02; sel = 5'd1;
        repeat (17) step();
        inc = '0; step();
        chk("wrap_cnt", rd_obs(0), 32'd1);
        chk("sat_cnt",  rd_obs(1), 32'd15);
        chk("wrap_ovf", {31'd0, ov0[1]}, 32'd1);
        chk("sat_ovf",  {31'd0, ov1[1]}, 32'd1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_ovf_wrap", ov_obs(0), 32'd0);
        chk("clr_ovf_sat",  ov_obs(1), 32'd0);
        step();
        chk("clr_cnt_wrap", rd_obs(0), 32'd0);
        chk("clr_cnt_sat",  rd_obs(1), 32'd0);

        // snap + clear + inc in the same cycle
        inc = 8'h01;
        repeat (7) step();
        snap = 1'b1; clear = 1'b1; step();
        snap = 1'b0; clear = 1'b0; inc = '0;
        sel = 5'd0; rd_snap = 1'b1; step();
        chk("prio_snap", rd_obs(0), 32'd7);
        chk("prio_valid", sv_obs(0), 32'd1);
        rd_snap = 1'b0; step();
        chk("prio_live", rd_obs(0), 32'd0);

        // Read mux: out-of-range select and live/snapshot swap latency
        sel = 5'd9; step();
        chk("sel9_live", rd_obs(0), 32'd0);
        rd_snap = 1'b1; step();
        chk("sel9_snap", rd_obs(0), 32'd0);
        sel = 5'd0; step();
        chk("swap_snap", rd_obs(0), 32'd7);
        rd_snap = 1'b0; step();
        chk("swap_live", rd_obs(0), 32'd0);

        // Windowing with the enable held high
        clear = 1'b1; step(); clear = 1'b0;
        inc = 8'h01; en = 1'b1; sel = 5'd0; rd_snap = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            step();
            chk($sformatf("win_tick_s%0d", s), {31'd0, wt2}, {31'd0, (s % 4) == 0});
            if (s == 5 || s == 9) chk($sformatf("win_snap_s%0d", s), rd_obs(2), 32'd4);
        end

        // Two disabled cycles stretch the window period to six
        clear = 1'b1; step(); clear = 1'b0;
        for (int s = 1; s <= 12; s++) begin
            en = !(s == 2 || s == 3);
            step();
            chk($sformatf("win_stretch_s%0d", s), {31'd0, wt2}, {31'd0, (s == 6 || s == 10)});
        end
        en = 1'b1;
        repeat (3) step();

        // Asynchronous reset mid-run, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("async_rd[%0d]", k),  rd_obs(k), 32'd0);
            chk($sformatf("async_ov[%0d]", k),  ov_obs(k), 32'd0);
            chk($sformatf("async_sv[%0d]", k),  sv_obs(k), 32'd0);
        end
        #1 rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            en      = ($urandom_range(0, 9) != 0);
            inc     = 8'($urandom);
            clear   = ($urandom_range(0, 39) == 0);
            snap    = ($urandom_range(0, 19) == 0);
            sel     = 5'($urandom_range(0, 11));
            rd_snap = 1'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
